// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: {co,s} = a + b + cin, CHUNK bits per clock with the carry
// held in a register between chunks. start/busy/done handshake, signed overflow flag.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_psum_next;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Current chunk sum, merged into the partial sum so the final edge can publish it directly
    always_comb begin
        w_chunk_sum = add_chunk(r_a[r_idx*CHUNK +: CHUNK], r_b[r_idx*CHUNK +: CHUNK], r_carry);
        w_psum_next = r_psum;
        w_psum_next[r_idx*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_psum  <= w_psum_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    // Results are only published here, so s/co/ovf hold the previous value throughout RUN
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_psum_next;
                        r_co    <= w_chunk_sum[CHUNK];
                        r_ovf   <= signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_psum_next[WIDTH-1]);
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: 16/4 directed cases plus 8/8 and 12/3 sweeps
// against an a+b+cin reference; one monitor pops expected results on each done pulse.
module tb_chunked_serial_adder;

    localparam int NCH16 = 4;
    localparam int NCH8  = 1;
    localparam int NCH12 = 4;

    typedef struct {
        logic [16:0] v;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    logic fin_req = 1'b0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q12[$];

    logic        rst16, start16, cin16, busy16, done16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    logic        rst_sw, st8, ci8, bz8, dn8, co8, ov8;
    logic [7:0]  a8, b8, s8;
    logic        st12, ci12, bz12, dn12, co12, ov12;
    logic [11:0] a12, b12, s12;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .s(s16), .co(co16), .ovf(ovf16));

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst_sw), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(bz8), .done(dn8), .s(s8), .co(co8), .ovf(ov8));

    chunked_serial_adder #(.WIDTH(12), .CHUNK(3)) u_dut12 (
        .clk(clk), .rst(rst_sw), .start(st12), .a(a12), .b(b12), .cin(ci12),
        .busy(bz12), .done(dn12), .s(s12), .co(co12), .ovf(ov12));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge
    logic [17:0] last16 = '0;
    int          bc16 = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst16) begin
            chk("rst_s", 32'(s16), 0);
            chk("rst_flags", 32'({busy16, done16, co16, ovf16}), 0);
            last16 = '0;
            bc16 = 0;
        end else begin
            chk("busy_done_excl", 32'(busy16 & done16), 0);
            if (busy16) begin
                bc16++;
                chk("s_hold", 32'({co16, ovf16, s16}), 32'(last16));
            end
            if (done16) begin
                chk("busy_len", 32'(bc16), NCH16);
                bc16 = 0;
                chk("done16_expected", 32'(q16.size() != 0), 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("sum16", 32'({co16, s16}), 32'(e.v));
                    chk("ovf16", 32'(ovf16), 32'(e.ovf));
                    chk("lat16", cyc, e.cyc);
                    last16 = {co16, ovf16, s16};
                end
            end else if (!busy16) begin
                bc16 = 0;
            end
        end
        if (!rst_sw) begin
            if (dn8) begin
                chk("done8_expected", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("sum8", 32'({co8, s8}), 32'(e.v));
                    chk("ovf8", 32'(ov8), 32'(e.ovf));
                    chk("lat8", cyc, e.cyc);
                end
            end
            if (dn12) begin
                chk("done12_expected", 32'(q12.size() != 0), 1);
                if (q12.size() != 0) begin
                    e = q12.pop_front();
                    chk("sum12", 32'({co12, s12}), 32'(e.v));
                    chk("ovf12", 32'(ov12), 32'(e.ovf));
                    chk("lat12", cyc, e.cyc);
                end
            end
        end
        if (fin_req) begin
            chk("drain16", q16.size(), 0);
            chk("drain8", q8.size(), 0);
            chk("drain12", q12.size(), 0);
        end
    end

    // Drive one request; the next rising edge is the accepting edge
    task automatic send16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [16:0] ev, input logic eo);
        start16 = 1'b1;
        a16 = ta;
        b16 = tb_v;
        cin16 = tc;
        q16.push_back('{ev, eo, cyc + 1 + NCH16});
        @(posedge clk); #1;
    endtask

    initial begin
        rst16 = 1'b0; rst_sw = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        st12 = 1'b0; a12 = '0; b12 = '0; ci12 = 1'b0;
        #1;
        rst16 = 1'b1; rst_sw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst16 = 1'b0; rst_sw = 1'b0;
        @(posedge clk); #1;

        fork
            begin
                send16(16'h0002, 16'h0003, 1'b1, 17'h00006, 1'b0);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;
                send16(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;
                send16(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;
                send16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;

                // start pulsed mid-RUN must be ignored
                send16(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
                start16 = 1'b0; @(posedge clk); #1;
                start16 = 1'b1; a16 = 16'h1111; b16 = 16'h1111;
                @(posedge clk); #1;
                start16 = 1'b0; repeat (5) @(posedge clk); #1;

                // start held high: second pair accepted in the DONE cycle
                send16(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0);
                repeat (NCH16) @(posedge clk); #1;
                send16(16'h00F0, 16'h0F0F, 1'b0, 17'h00FFF, 1'b0);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;

                // reset mid-RUN aborts; the aborted request produces no result
                send16(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0);
                start16 = 1'b0; @(posedge clk); #1;
                rst16 = 1'b1;
                q16.delete(q16.size() - 1);
                repeat (2) @(posedge clk); #1;
                rst16 = 1'b0;
                repeat (6) @(posedge clk); #1;
                send16(16'h8000, 16'h8000, 1'b1, 17'h10001, 1'b1);
                start16 = 1'b0; repeat (5) @(posedge clk); #1;
            end
            begin
                logic [7:0] ra, rb;
                logic       rc;
                logic [8:0] sum;
                for (int i = 0; i < 1000; i++) begin
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
                    st8 = 1'b1; a8 = ra; b8 = rb; ci8 = rc;
                    q8.push_back('{17'(sum), (ra[7] == rb[7]) && (sum[7] != ra[7]), cyc + 1 + NCH8});
                    @(posedge clk); #1;
                    st8 = 1'b0;
                    repeat (NCH8) @(posedge clk); #1;
                end
            end
            begin
                logic [11:0] ra, rb;
                logic        rc;
                logic [12:0] sum;
                for (int i = 0; i < 1000; i++) begin
                    ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom);
                    sum = {1'b0, ra} + {1'b0, rb} + {12'd0, rc};
                    st12 = 1'b1; a12 = ra; b12 = rb; ci12 = rc;
                    q12.push_back('{17'(sum), (ra[11] == rb[11]) && (sum[11] != ra[11]), cyc + 1 + NCH12});
                    @(posedge clk); #1;
                    st12 = 1'b0;
                    repeat (NCH12) @(posedge clk); #1;
                end
            end
        join

        for (int i = 0; i < 40 && (q16.size() + q8.size() + q12.size()) > 0; i++)
            @(posedge clk);
        #1;
        fin_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
